// File: rtl/de1_soc_pio_pkg.sv
// Shared constants and types for the DE1-SoC key PIO: register addresses,
// edge selection and debounce counter sizing.
package de1_soc_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    typedef enum logic [1:0] {
        RISING  = 2'd0,
        FALLING = 2'd1,
        ANY     = 2'd2
    } edge_type_e;

    // Counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/de1_soc_keys_pio_if.sv
// Avalon-MM slave bus bundle for the key PIO register file.
interface de1_soc_keys_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/de1_soc_debounce_bit.sv
// One pad input: 2-flop synchronizer followed by a stable-run debounce counter.
module de1_soc_debounce_bit
    import de1_soc_pio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic        IDLE_VALUE      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pad_i,
    output logic db_o
);

    localparam int unsigned     CntW    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            db_q, db_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            db_d  = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= IDLE_VALUE;
            sync2_q <= IDLE_VALUE;
            db_q    <= IDLE_VALUE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pad_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db_o = db_q;

endmodule

// File: rtl/de1_soc_keys_pio_regs.sv
// Register file: data readback, interrupt mask, edge capture and irq.
module de1_soc_keys_pio_regs
    import de1_soc_pio_pkg::*;
#(
    parameter int unsigned      WIDTH      = 4,
    parameter edge_type_e       EDGE_TYPE  = FALLING,
    parameter logic [WIDTH-1:0] IDLE_VALUE = '1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    de1_soc_keys_pio_if.slave    bus,
    input  logic [WIDTH-1:0]     db_i,
    output logic                 irq_o
);

    logic [WIDTH-1:0] db_prev_q;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] hit, clr;
    logic             wr_en;
    logic             unused_writedata;

    assign wr_en            = bus.chipselect & ~bus.write_n;
    assign unused_writedata = ^bus.writedata;

    always_comb begin
        case (EDGE_TYPE)
            RISING:  hit = ~db_prev_q & db_i;
            FALLING: hit = db_prev_q & ~db_i;
            default: hit = db_prev_q ^ db_i;
        endcase
    end

    // A new edge wins over a same-cycle write-1-clear.
    always_comb begin
        mask_d = mask_q;
        clr    = '0;
        if (wr_en && bus.address == ADDR_MASK) mask_d = bus.writedata[WIDTH-1:0];
        if (wr_en && bus.address == ADDR_EDGE) clr = bus.writedata[WIDTH-1:0];
        cap_d = (cap_q & ~clr) | hit;
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA: bus.readdata[WIDTH-1:0] = db_i;
            ADDR_MASK: bus.readdata[WIDTH-1:0] = mask_q;
            ADDR_EDGE: bus.readdata[WIDTH-1:0] = cap_q;
            default:   bus.readdata = '0;
        endcase
    end

    assign irq_o = |(cap_q & mask_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_prev_q <= IDLE_VALUE;
            mask_q    <= '0;
            cap_q     <= '0;
        end else begin
            db_prev_q <= db_i;
            mask_q    <= mask_d;
            cap_q     <= cap_d;
        end
    end

endmodule

// File: rtl/de1_soc_keys_pio.sv
// DE1-SoC KEY parallel input port: debounced pads, edge capture and a
// level interrupt behind a 4-word Avalon-MM slave.
module de1_soc_keys_pio
    import de1_soc_pio_pkg::*;
#(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      DEBOUNCE_CYCLES = 50000,
    parameter edge_type_e       EDGE_TYPE       = FALLING,
    parameter logic [WIDTH-1:0] IDLE_VALUE      = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    de1_soc_keys_pio_if bus_if ();

    assign bus_if.address    = address;
    assign bus_if.chipselect = chipselect;
    assign bus_if.write_n    = write_n;
    assign bus_if.writedata  = writedata;
    assign readdata          = bus_if.readdata;

    logic [WIDTH-1:0] db;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        de1_soc_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_VALUE      (IDLE_VALUE[i])
        ) u_db (
            .clk     (clk),
            .reset_n (reset_n),
            .pad_i   (in_port[i]),
            .db_o    (db[i])
        );
    end

    de1_soc_keys_pio_regs #(
        .WIDTH      (WIDTH),
        .EDGE_TYPE  (EDGE_TYPE),
        .IDLE_VALUE (IDLE_VALUE)
    ) u_regs (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if),
        .db_i    (db),
        .irq_o   (irq)
    );

endmodule

// File: tb/tb_de1_soc_keys_pio.sv
// Bench for de1_soc_keys_pio: per-cycle model compare plus directed literal checks.
module tb_de1_soc_keys_pio;
    import de1_soc_pio_pkg::*;

    localparam int W  = 4;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] in_port = '1;
    logic         irq;

    de1_soc_keys_pio_if bus ();

    always #5 clk = ~clk;

    de1_soc_keys_pio #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC),
        .EDGE_TYPE       (FALLING),
        .IDLE_VALUE      (4'hF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (bus.address),
        .chipselect (bus.chipselect),
        .write_n    (bus.write_n),
        .writedata  (bus.writedata),
        .readdata   (bus.readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    int tests = 0;
    int fails = 0;
    bit started = 1'b0;

    // Model: synchronizer history, run length of disagreement, accepted level.
    logic [W-1:0] m_s1, m_s2, m_db, m_prev, m_mask, m_cap;
    int           m_run [W];
    logic         m_wr;
    logic [W-1:0] m_clr;

    assign m_wr  = bus.chipselect && !bus.write_n;
    assign m_clr = (m_wr && bus.address == ADDR_EDGE) ? bus.writedata[W-1:0] : '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1   <= '1;
            m_s2   <= '1;
            m_db   <= '1;
            m_prev <= '1;
            m_mask <= '0;
            m_cap  <= '0;
            for (int i = 0; i < W; i++) m_run[i] <= 0;
        end else begin
            m_s1   <= in_port;
            m_s2   <= m_s1;
            m_prev <= m_db;
            for (int i = 0; i < W; i++) begin
                if (m_s2[i] !== m_db[i]) begin
                    if (m_run[i] + 1 >= DC) begin
                        m_db[i]  <= m_s2[i];
                        m_run[i] <= 0;
                    end else begin
                        m_run[i] <= m_run[i] + 1;
                    end
                end else begin
                    m_run[i] <= 0;
                end
            end
            if (m_wr && bus.address == ADDR_MASK) m_mask <= bus.writedata[W-1:0];
            m_cap <= (m_cap & ~m_clr) | (m_prev & ~m_db);
        end
    end

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {28'b0, m_db};
            2'd1:    return {28'b0, m_mask};
            2'd3:    return {28'b0, m_cap};
            default: return 32'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset_n && started) begin
            tests++;
            if (bus.readdata !== exp_rd(bus.address)) begin
                fails++;
                $display("FAIL model_readdata addr=%0d got=%h exp=%h t=%0t",
                         bus.address, bus.readdata, exp_rd(bus.address), $time);
            end
            tests++;
            if (irq !== |(m_cap & m_mask)) begin
                fails++;
                $display("FAIL model_irq got=%b exp=%b t=%0t", irq, |(m_cap & m_mask), $time);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        @(posedge clk);
        #1 bus.address = a;
        @(negedge clk);
        #1 chk(name, bus.readdata, exp);
    endtask

    task automatic chk_irq(input logic exp, input string name);
        @(negedge clk);
        #1 chk(name, {31'b0, irq}, {31'b0, exp});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        started = 1'b1;

        rd(2'd0, 32'h0000000F, "reset_data");
        rd(2'd1, 32'h0, "reset_mask");
        rd(2'd3, 32'h0, "reset_edge");
        rd(2'd2, 32'h0, "reserved_read");
        chk_irq(1'b0, "reset_irq");

        // Glitch shorter than the debounce window.
        @(posedge clk);
        #1 in_port[0] = 1'b0;
        idle(3);
        in_port[0] = 1'b1;
        idle(10);
        rd(2'd0, 32'h0000000F, "short_data");
        rd(2'd3, 32'h0, "short_edge");

        in_port[0] = 1'b0;
        idle(12);
        rd(2'd0, 32'h0000000E, "press0_data");
        rd(2'd3, 32'h1, "press0_edge");
        chk_irq(1'b0, "press0_irq_masked");

        wr(2'd1, 32'h1);
        chk_irq(1'b1, "mask_irq_on");
        wr(2'd1, 32'h0);
        chk_irq(1'b0, "mask_irq_off");
        rd(2'd3, 32'h1, "mask_edge_kept");

        wr(2'd1, 32'h1);
        chk_irq(1'b1, "clr_irq_before");
        wr(2'd3, 32'h1);
        chk_irq(1'b0, "clr_irq");
        rd(2'd3, 32'h0, "clr_edge");
        wr(2'd3, 32'h0);
        rd(2'd3, 32'h0, "clr_zero_write");

        // Clear bit 2 in the very cycle its new falling edge lands.
        @(posedge clk);
        #1;
        bus.address = 2'd0;
        in_port[2]  = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.readdata[2] == 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        if (done) begin
            bus.address    = 2'd3;
            bus.chipselect = 1'b1;
            bus.write_n    = 1'b0;
            bus.writedata  = 32'h4;
            @(posedge clk);
            #1;
            bus.chipselect = 1'b0;
            bus.write_n    = 1'b1;
            bus.writedata  = '0;
        end else begin
            tests++;
            fails++;
            $display("FAIL collide_timeout got=no_debounce exp=bit2_low");
        end
        rd(2'd3, 32'h4, "collide_edge");
        chk_irq(1'b0, "collide_irq_masked");
        wr(2'd3, 32'h0);
        rd(2'd3, 32'h4, "zero_write_keeps");
        wr(2'd3, 32'h4);
        rd(2'd3, 32'h0, "collide_cleared");

        in_port[1] = 1'b0;
        idle(12);
        rd(2'd0, 32'h00000008, "press1_data");
        rd(2'd3, 32'h2, "press1_edge");
        wr(2'd3, 32'h2);
        rd(2'd3, 32'h0, "press1_cleared");
        in_port[1] = 1'b1;
        idle(12);
        rd(2'd0, 32'h0000000A, "release1_data");
        rd(2'd3, 32'h0, "release1_no_edge");

        // Reset asserted part-way through a debounce.
        in_port[3] = 1'b0;
        idle(4);
        reset_n = 1'b0;
        idle(2);
        in_port = '1;
        reset_n = 1'b1;
        rd(2'd0, 32'h0000000F, "rst_mid_data");
        rd(2'd1, 32'h0, "rst_mid_mask");
        idle(12);
        rd(2'd3, 32'h0, "rst_mid_edge");
        chk_irq(1'b0, "rst_mid_irq");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
